// File: rtl/uart_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | uart_arb_pkg
// | UART register map, init-step encoding and lane/divisor helpers.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
package uart_arb_pkg;

    localparam logic [2:0] RBR_THR = 3'd0;
    localparam logic [2:0] IER     = 3'd1;
    localparam logic [2:0] IIR_FCR = 3'd2;
    localparam logic [2:0] LCR     = 3'd3;
    localparam logic [2:0] MCR     = 3'd4;
    localparam logic [2:0] LSR     = 3'd5;
    localparam logic [2:0] MSR     = 3'd6;
    localparam logic [2:0] SPR     = 3'd7;

    localparam int LCR_DLAB_BIT = 7;

    typedef enum logic [2:0] {
        INIT_LCR_DLAB = 3'd0,
        INIT_DLL      = 3'd1,
        INIT_DLM      = 3'd2,
        INIT_LCR_8N1  = 3'd3,
        INIT_FCR      = 3'd4,
        INIT_IER      = 3'd5,
        INIT_DONE     = 3'd6
    } init_step_e;

    function automatic logic [15:0] calc_divisor(input int unsigned clk_freq,
                                                 input int unsigned baud);
        int unsigned q;
        q = clk_freq / (16 * baud);
        return q[15:0];
    endfunction

    // lendian = 1 selects d[7:0]; 0 selects d[31:24]
    function automatic logic [31:0] place_byte(input logic [7:0] b, input logic lendian);
        return lendian ? {24'h0, b} : {b, 24'h0};
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic lendian);
        return lendian ? d[7:0] : d[31:24];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | uart_port_arbiter_if
// | 16550 register-port bus: requester drives a/d/rd/we, responder spo/ready.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
interface uart_port_arbiter_if;
    logic [2:0]  a;
    logic [31:0] d;
    logic        rd;
    logic        we;
    logic [31:0] spo;
    logic        ready;

    modport master (output a, d, rd, we, input  spo, ready);
    modport slave  (input  a, d, rd, we, output spo, ready);
endinterface
`default_nettype wire

// File: rtl/uart_init_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | uart_init_seq
// | Post-reset writer: LCR(DLAB), DLL, DLM, LCR 8N1, FCR, IER, one per ready.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
module uart_init_seq
    import uart_arb_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 62500000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int          LENDIAN    = 0,
    parameter logic [7:0]  FCR_INIT   = 8'h07
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_ready,
    output logic [2:0]       o_a,
    output logic [31:0]      o_d,
    output logic             o_we,
    output logic             o_done
);

    localparam logic [15:0] c_DIV = calc_divisor(CLOCK_FREQ, BAUD_RATE);

    init_step_e r_step;
    init_step_e w_step_next;
    logic [7:0] w_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step <= INIT_LCR_DLAB;
        end else begin
            r_step <= w_step_next;
        end
    end

    always_comb begin
        w_step_next = r_step;
        o_a         = RBR_THR;
        w_byte      = 8'h00;
        o_we        = 1'b1;
        case (r_step)
            INIT_LCR_DLAB: begin
                o_a    = LCR;
                w_byte = 8'h83;
                if (i_ready) w_step_next = INIT_DLL;
            end
            INIT_DLL: begin
                o_a    = RBR_THR;
                w_byte = c_DIV[7:0];
                if (i_ready) w_step_next = INIT_DLM;
            end
            INIT_DLM: begin
                o_a    = IER;
                w_byte = c_DIV[15:8];
                if (i_ready) w_step_next = INIT_LCR_8N1;
            end
            INIT_LCR_8N1: begin
                o_a    = LCR;
                w_byte = 8'h03;
                if (i_ready) w_step_next = INIT_FCR;
            end
            INIT_FCR: begin
                o_a    = IIR_FCR;
                w_byte = FCR_INIT;
                if (i_ready) w_step_next = INIT_IER;
            end
            INIT_IER: begin
                o_a    = IER;
                w_byte = 8'h00;
                if (i_ready) w_step_next = INIT_DONE;
            end
            default: begin
                o_we = 1'b0;
            end
        endcase
    end

    assign o_d    = o_we ? place_byte(w_byte, LENDIAN != 0) : 32'h0;
    assign o_done = (r_step == INIT_DONE);

endmodule
`default_nettype wire

// File: rtl/uart_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | uart_port_arbiter
// | Round-robin share of one UART port between m0 and m1 with DLAB lock.
// | Optional init sequencer enabled by `define UART_ARB_INIT_EN.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
module uart_port_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 62500000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int          LENDIAN    = 0,
    parameter logic [7:0]  FCR_INIT   = 8'h07
) (
    input  wire logic             clk,
    input  wire logic             rst,
    uart_port_arbiter_if.slave    m0,
    uart_port_arbiter_if.slave    m1,
    uart_port_arbiter_if.master   u,
    output logic                  init_done
);

    logic        w_init_done;
    logic [2:0]  w_seq_a;
    logic [31:0] w_seq_d;
    logic        w_seq_we;

`ifdef UART_ARB_INIT_EN
    uart_init_seq #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .LENDIAN    (LENDIAN),
        .FCR_INIT   (FCR_INIT)
    ) u_init_seq (
        .clk     (clk),
        .rst     (rst),
        .i_ready (u.ready),
        .o_a     (w_seq_a),
        .o_d     (w_seq_d),
        .o_we    (w_seq_we),
        .o_done  (w_init_done)
    );
`else
    assign w_init_done = 1'b1;
    assign w_seq_a     = 3'd0;
    assign w_seq_d     = 32'h0;
    assign w_seq_we    = 1'b0;
`endif

    assign init_done = w_init_done;

    logic r_last;    // 0 = m0 served last, 1 = m1
    logic r_locked;
    logic r_owner;

    logic w_req0, w_req1;
    logic w_gnt0, w_gnt1;
    logic w_acc;
    logic [2:0]  w_gnt_a;
    logic [31:0] w_gnt_d;
    logic        w_gnt_we;
    logic [7:0]  w_lcr_byte;

    assign w_req0 = m0.rd | m0.we;
    assign w_req1 = m1.rd | m1.we;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst && w_init_done) begin
            if (r_locked) begin
                if (r_owner) w_gnt1 = w_req1;
                else         w_gnt0 = w_req0;
            end else if (w_req0 && w_req1) begin
                if (r_last) w_gnt0 = 1'b1;
                else        w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = w_req0;
                w_gnt1 = w_req1;
            end
        end
    end

    assign w_gnt_a    = w_gnt1 ? m1.a  : m0.a;
    assign w_gnt_d    = w_gnt1 ? m1.d  : m0.d;
    assign w_gnt_we   = w_gnt1 ? m1.we : m0.we;
    assign w_lcr_byte = lane_byte(w_gnt_d, LENDIAN != 0);
    assign w_acc      = (w_gnt0 | w_gnt1) & u.ready;

    always_comb begin
        u.a      = 3'd0;
        u.d      = 32'h0;
        u.rd     = 1'b0;
        u.we     = 1'b0;
        m0.spo   = 32'h0;
        m0.ready = 1'b0;
        m1.spo   = 32'h0;
        m1.ready = 1'b0;
        if (!rst && !w_init_done) begin
            u.a  = w_seq_a;
            u.d  = w_seq_d;
            u.we = w_seq_we;
        end else if (w_gnt0) begin
            u.a      = m0.a;
            u.d      = m0.d;
            u.we     = m0.we;
            u.rd     = m0.rd & ~m0.we;
            m0.spo   = u.spo;
            m0.ready = u.ready;
        end else if (w_gnt1) begin
            u.a      = m1.a;
            u.d      = m1.d;
            u.we     = m1.we;
            u.rd     = m1.rd & ~m1.we;
            m1.spo   = u.spo;
            m1.ready = u.ready;
        end
    end

    // Only the owner can be granted while locked, so a DLAB-clear write is always the owner's
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last   <= 1'b1;
            r_locked <= 1'b0;
            r_owner  <= 1'b0;
        end else if (w_acc) begin
            r_last <= w_gnt1;
            if (w_gnt_we && (w_gnt_a == LCR)) begin
                if (w_lcr_byte[LCR_DLAB_BIT]) begin
                    r_locked <= 1'b1;
                    r_owner  <= w_gnt1;
                end else if (r_owner == w_gnt1) begin
                    r_locked <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_port_arbiter.md
# uart_port_arbiter

Shares the register port of one 16550-compatible UART between two bus requesters: the CPU (m0) and a secondary master (m1), e.g. a debug monitor or boot loader. Round-robin arbitration with a DLAB lock keeps each divisor-programming sequence atomic. An optional reset-time sequencer programs baud rate, line format and FIFO control before either master is served. Sits between the bus interconnect and the UART instance.

## Interface
- CLOCK_FREQ, 62500000: system clock in Hz.
- BAUD_RATE, 115200: baud rate programmed by the init sequence.
- LENDIAN, 0: byte lane; 1 = d[7:0], 0 = d[31:24]. Matches the UART's lane setting.
- FCR_INIT, 8'h07: FCR value written by the init sequence.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- m0_a / m1_a  in  3  register address.
- m0_d / m1_d  in  32  write data.
- m0_rd / m1_rd  in  1  read request; held until ready.
- m0_we / m1_we  in  1  write request; held until ready.
- m0_spo / m1_spo  out  32  read data; valid while the matching ready is high.
- m0_ready / m1_ready  out  1  access accepted this cycle.
- u_a  out  3  to UART.
- u_d  out  32  to UART.
- u_rd  out  1  to UART.
- u_we  out  1  to UART.
- u_spo  in  32  from UART.
- u_ready  in  1  from UART.
- init_done  out  1  high once the init sequence has completed; constant 1 when the sequencer is compiled out.

## Operation
- A master requests when rd|we is high. rd and we are never high together; if both are set, the request is treated as a write.
- Grant is combinational from current requests, the last-served pointer `last` and the lock state.
  - Locked: only the lock owner may be granted.
  - Unlocked, single requester: that requester is granted.
  - Unlocked, both requesting: the master other than `last` is granted.
- Granted master: its a/d/rd/we drive u_*. Its spo = u_spo and its ready = u_ready. All other readies are 0 and all other spo are 0.
- No grant: u_rd = u_we = 0; u_a and u_d hold the value 0.
- On an accepted access (ready high), `last` is set to the granted master.
- Lock set: an accepted write to a=3 (LCR) with data bit7 = 1 locks to the writer.
- Lock clear: an accepted write to a=3 with bit7 = 0 by the owner clears the lock.
- Any read, and any write other than to LCR, leaves the lock unchanged.
- Init sequencer (INIT state):
  - Issues six writes, one per cycle when u_ready is high: LCR=8'h83, DLL=DIV[7:0], DLM=DIV[15:8], LCR=8'h03, FCR=FCR_INIT, IER=8'h00.
  - DIV = CLOCK_FREQ/(16*BAUD_RATE), truncated to 16 bits.
  - Each byte is placed on the lane selected by LENDIAN; all other bits are 0.
  - Both masters see ready = 0 throughout. When the sequence finishes, init_done rises and arbitration begins.

## Timing
- Reset values: `last` = m1 (so m0 wins the first tie), unlocked, init_done = 0 (1 with the sequencer compiled out), all readies 0, u_rd = u_we = 0, u_a = 0, u_d = 0, m*_spo = 0.
- Access latency is zero: a request seen in cycle N with u_ready high completes in cycle N. Read data is the combinational u_spo.
- Lock and `last` update at the clock edge ending the accepted cycle. The other master can be served in the next cycle at the earliest.
- Init takes 6 cycles at u_ready = 1. u_ready low stalls the current step. init_done is high from the cycle after the IER write.
- Reset asserted mid-access or mid-init: the access is aborted, all state returns to reset values, and init restarts from LCR=8'h83.
- Masters that keep requesting alternate every cycle. A locked owner may hold the port indefinitely; software is responsible for clearing DLAB.

## Configuration
- UART_ARB_INIT_EN defined: the init sequencer is present and runs after every reset.
- UART_ARB_INIT_EN undefined: no sequencer, init_done is tied to 1, and arbitration starts in the first cycle after reset. The UART keeps its own reset defaults.

## Structure
- Package uart_arb_pkg holds:
  - Register address constants: RBR_THR=0, IER=1, IIR_FCR=2, LCR=3, MCR=4, LSR=5, MSR=6, SPR=7.
  - LCR_DLAB_BIT=7.
  - The init-step enum.
  - The divisor function.
- Sub-module uart_init_seq: step counter plus write generator, instantiated only under UART_ARB_INIT_EN.

## Test plan
- CLOCK_FREQ=62500000, BAUD_RATE=115200, LENDIAN=0, init enabled: after reset, u_we pulses on a=3/0/1/3/2/1 with d[31:24]=83/21/00/03/07/00. init_done rises in cycle 7.
- Both masters read a=5 continuously: grants go m0, m1, m0, m1, and each spo equals u_spo in its granted cycle.
- m1 writes LCR=8'h80, then DLL=8'h10, then LCR=8'h03 while m0 requests throughout: m0_ready stays 0 until the cycle after m1's LCR=8'h03 write is accepted.
- u_ready held at 0 for 3 cycles during a m0 write: m0_ready stays 0 and u_we stays high. The write completes on the first cycle u_ready = 1.
- rst asserted during init step DLM: the next cycle outputs u_a=3 with data 8'h83, and init_done = 0.
- Init disabled: m0_we to a=0 in the first post-reset cycle gives m0_ready = 1 in that same cycle.
